// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - states, opcodes, pc_src/ALU encodings and decode helpers for the control unit
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;

  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_MOVI  = 4'b0001;
  localparam logic [3:0] OP_JUMP  = 4'b0010;
  localparam logic [3:0] OP_ADDI  = 4'b0100;
  localparam logic [3:0] OP_SUBI  = 4'b0101;
  localparam logic [3:0] OP_BEQ   = 4'b1000;
  localparam logic [3:0] OP_BNE   = 4'b1001;
  localparam logic [3:0] OP_BGT   = 4'b1010;
  localparam logic [3:0] OP_LW    = 4'b1011;
  localparam logic [3:0] OP_BLT   = 4'b1100;
  localparam logic [3:0] OP_BGE   = 4'b1101;
  localparam logic [3:0] OP_BLE   = 4'b1110;
  localparam logic [3:0] OP_SW    = 4'b1111;

  localparam logic [1:0] PC_SRC_INC    = 2'b00;
  localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_NOR = 3'b101;
  localparam logic [2:0] ALU_SHL = 3'b110;
  localparam logic [2:0] ALU_SHR = 3'b111;

  typedef struct packed {
    logic       alu_src;
    logic       reg_src;
    logic [2:0] alu_op;
  } exec_ctrl_t;

  function automatic logic [2:0] func_to_aluctl(input logic [2:0] f);
    logic [2:0] r;
    case (f)
      3'b000:  r = ALU_ADD;
      3'b010:  r = ALU_SUB;
      3'b100:  r = ALU_AND;
      3'b101:  r = ALU_OR;
      3'b001:  r = ALU_XOR;
      3'b011:  r = ALU_NOR;
      3'b110:  r = ALU_SHL;
      default: r = ALU_SHR;
    endcase
    return r;
  endfunction

  function automatic logic op_is_legal(input logic [3:0] op);
    return !(op == 4'b0011 || op == 4'b0110 || op == 4'b0111);
  endfunction

  function automatic logic op_is_alu(input logic [3:0] op);
    return op == OP_RTYPE || op == OP_MOVI || op == OP_ADDI || op == OP_SUBI;
  endfunction

  function automatic logic op_is_mem(input logic [3:0] op);
    return op == OP_LW || op == OP_SW;
  endfunction

  function automatic logic op_is_branch(input logic [3:0] op);
    return op[3] && !op_is_mem(op);
  endfunction

  function automatic exec_ctrl_t exec_ctrl(input logic [3:0] op, input logic [2:0] f);
    exec_ctrl_t e;
    e.alu_src = 1'b0;
    e.reg_src = 1'b0;
    e.alu_op  = ALU_ADD;
    case (op)
      OP_RTYPE:       e.alu_op = func_to_aluctl(f);
      OP_MOVI,
      OP_ADDI:        e.alu_src = 1'b1;
      OP_SUBI: begin
        e.alu_src = 1'b1;
        e.alu_op  = ALU_SUB;
      end
      OP_LW, OP_SW: begin
        e.alu_src = 1'b1;
        e.reg_src = 1'b1;
      end
      default: begin
        // branches compare rs against rd with a subtract
        if (op_is_branch(op)) begin
          e.reg_src = 1'b1;
          e.alu_op  = ALU_SUB;
        end
      end
    endcase
    return e;
  endfunction

endpackage

// File: rtl/cu_branch_eval.sv
// rtl/cu_branch_eval.sv - branch condition evaluation from live ALU flags of the compare subtract
module cu_branch_eval
  import cpu_ctrl_pkg::*;
(
  input  logic [3:0] op,
  input  logic       v,
  input  logic       n,
  input  logic       z,
  output logic       taken
);

  logic lt;
  assign lt = n ^ v;

  always_comb begin
    taken = 1'b0;
    case (op)
      OP_BEQ:  taken = z;
      OP_BNE:  taken = ~z;
      OP_BGT:  taken = ~z & ~lt;
      OP_BLT:  taken = lt;
      OP_BGE:  taken = ~lt;
      OP_BLE:  taken = z | lt;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - FETCH/DECODE/EXEC/MEM/WB control FSM; CU_PERF_CNT_EN adds perf counters
module multicycle_control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 4,
  parameter int FUNC_W   = 3,
  parameter int ALUCTL_W = 3,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] op_code,
  input  logic [FUNC_W-1:0]   func,
  input  logic                v,
  input  logic                c,
  input  logic                n,
  input  logic                z,
  input  logic                mem_ack,
  output logic                mem_req,
  output logic                mem_we,
  output logic                iord,
  output logic                ir_we,
  output logic                pc_we,
  output logic [1:0]          pc_src,
  output logic                reg_write,
  output logic                mem_to_reg,
  output logic                alu_src,
  output logic                reg_src,
  output logic [ALUCTL_W-1:0] alu_control,
  output logic [3:0]          flags_q,
  output logic                illegal,
  output logic [CNT_W-1:0]    instr_retired,
  output logic [CNT_W-1:0]    stall_cycles
);

  state_t     state;
  logic [3:0] op;
  logic [2:0] fn;
  logic       taken;
  logic       fetch_ack;
  logic       to_fetch;
  exec_ctrl_t ec;

  assign op = op_code[3:0];
  assign fn = func[2:0];
  assign ec = exec_ctrl(op, fn);

  cu_branch_eval u_branch (
    .op    (op),
    .v     (v),
    .n     (n),
    .z     (z),
    .taken (taken)
  );

  // IR load and PC updates must land on the same edge as ack / live flags, so they are decoded from state
  assign fetch_ack = (state == S_FETCH) && mem_req && mem_ack;
  assign ir_we     = fetch_ack;

  always_comb begin
    pc_we  = fetch_ack;
    pc_src = PC_SRC_INC;
    if (state == S_EXEC) begin
      if (op == OP_JUMP) begin
        pc_we  = 1'b1;
        pc_src = PC_SRC_JUMP;
      end else if (op_is_branch(op) && taken) begin
        pc_we  = 1'b1;
        pc_src = PC_SRC_BRANCH;
      end
    end
  end

  assign to_fetch = (state == S_DECODE && !op_is_legal(op))
                 || (state == S_EXEC && !op_is_alu(op) && !op_is_mem(op))
                 || (state == S_MEM && mem_ack && mem_we)
                 || (state == S_WB);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_FETCH;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      iord        <= 1'b0;
      reg_write   <= 1'b0;
      mem_to_reg  <= 1'b0;
      alu_src     <= 1'b0;
      reg_src     <= 1'b0;
      alu_control <= '0;
      flags_q     <= '0;
      illegal     <= 1'b0;
    end else begin
      reg_write  <= 1'b0;
      mem_to_reg <= 1'b0;
      case (state)
        S_FETCH: begin
          if (fetch_ack) begin
            mem_req <= 1'b0;
            state   <= S_DECODE;
          end else begin
            mem_req <= 1'b1;
          end
        end
        S_DECODE: begin
          if (!op_is_legal(op)) begin
            illegal <= 1'b1;
          end else begin
            alu_src     <= ec.alu_src;
            reg_src     <= ec.reg_src;
            alu_control <= ALUCTL_W'(ec.alu_op);
            state       <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (op_is_alu(op)) begin
            flags_q   <= {v, c, n, z};
            reg_write <= 1'b1;
            state     <= S_WB;
          end else if (op_is_mem(op)) begin
            mem_req <= 1'b1;
            iord    <= 1'b1;
            mem_we  <= (op == OP_SW);
            state   <= S_MEM;
          end
        end
        S_MEM: begin
          if (mem_ack && !mem_we) begin
            mem_req    <= 1'b0;
            iord       <= 1'b0;
            reg_write  <= 1'b1;
            mem_to_reg <= 1'b1;
            state      <= S_WB;
          end
        end
        default: ;
      endcase
      // every return to FETCH opens the next instruction fetch immediately
      if (to_fetch) begin
        state       <= S_FETCH;
        mem_req     <= 1'b1;
        iord        <= 1'b0;
        mem_we      <= 1'b0;
        alu_src     <= 1'b0;
        reg_src     <= 1'b0;
        alu_control <= '0;
      end
    end
  end

`ifdef CU_PERF_CNT_EN
  logic retire;
  assign retire = to_fetch && (state != S_DECODE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instr_retired <= '0;
      stall_cycles  <= '0;
    end else begin
      if (retire && instr_retired != '1) instr_retired <= instr_retired + CNT_W'(1);
      if (mem_req && !mem_ack && stall_cycles != '1) stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end
`else
  assign instr_retired = '0;
  assign stall_cycles  = '0;
`endif

endmodule
